// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: grants one request at a time, drives a single bus cycle, waits a
// fixed slave latency and returns read data to the granted master with a one-cycle ack.
// Round-robin arbitration by default; define BUS_ARB_FIXED_PRIO_EN to make m0 always win ties.
module bus_arbiter #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_wr_i,
  input  logic [DATA_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_req_i,
  input  logic              m1_wr_i,
  input  logic [DATA_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              bus_rd_en_o,
  output logic              bus_wr_en_o,
  output logic [DATA_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  output logic              busy_o
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                gnt_q, gnt_d;      // 0 = m0, 1 = m1
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                win;

`ifdef BUS_ARB_FIXED_PRIO_EN
  // m0 wins whenever it requests; m1 only when m0 is idle.
  assign win = ~m0_req_i;
`else
  logic last_gnt_q, last_gnt_d;

  // Round-robin: on a tie the master that was not granted last time wins.
  always_comb begin
    if (m0_req_i && m1_req_i) begin
      win = ~last_gnt_q;
    end else begin
      win = m1_req_i;
    end
  end

  // Remember the most recent winner; reset to 1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // Next-state logic: arbitrate in idle, then walk access -> wait -> resp.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
`ifndef BUS_ARB_FIXED_PRIO_EN
    last_gnt_d = last_gnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (m0_req_i || m1_req_i) begin
          gnt_d   = win;
          wr_d    = win ? m1_wr_i : m0_wr_i;
          addr_d  = win ? m1_addr_i : m0_addr_i;
          wdata_d = win ? m1_data_i : m0_data_i;
          state_d = StAccess;
`ifndef BUS_ARB_FIXED_PRIO_EN
          last_gnt_d = win;
`endif
        end
      end
      StAccess: begin
        cnt_d   = CntLoad;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          // Read data is only returned to the master that issued the read.
          if (!wr_q) begin
            if (gnt_q) begin
              m1_rdata_d = bus_data_i;
            end else begin
              m0_rdata_d = bus_data_i;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    bus_rd_en_o = (state_q == StAccess) && !wr_q;
    bus_wr_en_o = (state_q == StAccess) && wr_q;
    bus_addr_o  = addr_q;
    bus_data_o  = wdata_q;
    m0_ack_o    = (state_q == StResp) && !gnt_q;
    m1_ack_o    = (state_q == StResp) && gnt_q;
    m0_data_o   = m0_rdata_q;
    m1_data_o   = m1_rdata_q;
    busy_o      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: cycle table at LATENCY=1 plus hand sequences for
// continuous contention and a LATENCY=3 instance.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, bus_din = 0;
  logic        m0_ack, m1_ack, rd_en, wr_en, busy;
  logic [31:0] m0_dout, m1_dout, bus_addr, bus_dout;

  logic        req2 = 0;
  logic [31:0] din2 = 0;
  logic        m0_ack2, m1_ack2, rd_en2, wr_en2, busy2;
  logic [31:0] m0_dout2, m1_dout2, bus_addr2, bus_dout2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.LATENCY(1), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_wr_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
    .m0_ack_o(m0_ack), .m0_data_o(m0_dout),
    .m1_req_i(m1_req), .m1_wr_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_data_o(m1_dout),
    .bus_rd_en_o(rd_en), .bus_wr_en_o(wr_en), .bus_addr_o(bus_addr), .bus_data_o(bus_dout),
    .bus_data_i(bus_din), .busy_o(busy)
  );

  bus_arbiter #(.LATENCY(3), .DATA_W(32)) u_dut3 (
    .clk(clk), .rst(rst),
    .m0_req_i(req2), .m0_wr_i(1'b0), .m0_addr_i(32'h50), .m0_data_i(32'h0),
    .m0_ack_o(m0_ack2), .m0_data_o(m0_dout2),
    .m1_req_i(1'b0), .m1_wr_i(1'b0), .m1_addr_i(32'h0), .m1_data_i(32'h0),
    .m1_ack_o(m1_ack2), .m1_data_o(m1_dout2),
    .bus_rd_en_o(rd_en2), .bus_wr_en_o(wr_en2), .bus_addr_o(bus_addr2), .bus_data_o(bus_dout2),
    .bus_data_i(din2), .busy_o(busy2)
  );

  typedef struct {
    logic        rst;
    logic        m0_req; logic m0_wr; logic [31:0] m0_addr; logic [31:0] m0_wdata;
    logic        m1_req; logic m1_wr; logic [31:0] m1_addr; logic [31:0] m1_wdata;
    logic [31:0] bus_din;
    logic        e_rd; logic e_wr; logic [31:0] e_addr; logic [31:0] e_dout;
    logic        e_m0_ack; logic [31:0] e_m0_d; logic e_m1_ack; logic [31:0] e_m1_d;
    logic        e_busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[19];

  initial begin
    int          n;
    int          dual;
    int          seq[8];
    int          at[8];
    int          ack_cnt2;
    int          ack_cyc2;
    logic [31:0] ack_dat2;
    logic        acked;

    //          rst m0: req wr addr          wdata         m1: req wr addr          wdata
    //          bus_din        | rd wr addr          dout          m0ack m0d           m1ack m1d busy
    // Reset, then idle with no requests.
    vecs[0]  = '{1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 32'h0,
                 0,0,32'h0,32'h0, 0,32'h0, 0,32'h0, 0};
    vecs[1]  = '{1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 32'h0,
                 0,0,32'h0,32'h0, 0,32'h0, 0,32'h0, 0};
    vecs[2]  = '{0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 32'h0,
                 0,0,32'h0,32'h0, 0,32'h0, 0,32'h0, 0};
    // m0 read 0x10 -> 0xDEADBEEF.
    vecs[3]  = '{0, 1,0,32'h10,32'h5555, 0,0,32'h0,32'h0, 32'h0,
                 1,0,32'h10,32'h5555, 0,32'h0, 0,32'h0, 1};
    vecs[4]  = '{0, 1,0,32'h10,32'h5555, 0,0,32'h0,32'h0, 32'h1111_1111,
                 0,0,32'h10,32'h5555, 0,32'h0, 0,32'h0, 1};
    vecs[5]  = '{0, 1,0,32'h10,32'h5555, 0,0,32'h0,32'h0, 32'hDEAD_BEEF,
                 0,0,32'h10,32'h5555, 1,32'hDEAD_BEEF, 0,32'h0, 1};
    vecs[6]  = '{0, 0,0,32'h10,32'h5555, 0,0,32'h0,32'h0, 32'h2222_2222,
                 0,0,32'h10,32'h5555, 0,32'hDEAD_BEEF, 0,32'h0, 0};
    // m1 write 0x8000_0000 <- 0xA5; m1 read data must not change.
    vecs[7]  = '{0, 0,0,32'h0,32'h0, 1,1,32'h8000_0000,32'hA5, 32'h0,
                 0,1,32'h8000_0000,32'hA5, 0,32'hDEAD_BEEF, 0,32'h0, 1};
    vecs[8]  = '{0, 0,0,32'h0,32'h0, 1,1,32'h8000_0000,32'hA5, 32'h3333_3333,
                 0,0,32'h8000_0000,32'hA5, 0,32'hDEAD_BEEF, 0,32'h0, 1};
    vecs[9]  = '{0, 0,0,32'h0,32'h0, 1,1,32'h8000_0000,32'hA5, 32'h4444_4444,
                 0,0,32'h8000_0000,32'hA5, 0,32'hDEAD_BEEF, 1,32'h0, 1};
    vecs[10] = '{0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 32'h0,
                 0,0,32'h8000_0000,32'hA5, 0,32'hDEAD_BEEF, 0,32'h0, 0};
    // m0 read 0x20 aborted by reset while waiting; no ack, everything cleared.
    vecs[11] = '{0, 1,0,32'h20,32'h0, 0,0,32'h0,32'h0, 32'h0,
                 1,0,32'h20,32'h0, 0,32'hDEAD_BEEF, 0,32'h0, 1};
    vecs[12] = '{0, 1,0,32'h20,32'h0, 0,0,32'h0,32'h0, 32'h0,
                 0,0,32'h20,32'h0, 0,32'hDEAD_BEEF, 0,32'h0, 1};
    vecs[13] = '{1, 1,0,32'h20,32'h0, 0,0,32'h0,32'h0, 32'h5555_5555,
                 0,0,32'h0,32'h0, 0,32'h0, 0,32'h0, 0};
    vecs[14] = '{0, 0,0,32'h20,32'h0, 0,0,32'h0,32'h0, 32'h5555_5555,
                 0,0,32'h0,32'h0, 0,32'h0, 0,32'h0, 0};
    // Fresh m1 read after reset completes normally.
    vecs[15] = '{0, 0,0,32'h0,32'h0, 1,0,32'h30,32'h77, 32'h0,
                 1,0,32'h30,32'h77, 0,32'h0, 0,32'h0, 1};
    vecs[16] = '{0, 0,0,32'h0,32'h0, 1,0,32'h30,32'h77, 32'h1234_5678,
                 0,0,32'h30,32'h77, 0,32'h0, 0,32'h0, 1};
    vecs[17] = '{0, 0,0,32'h0,32'h0, 1,0,32'h30,32'h77, 32'h1234_5678,
                 0,0,32'h30,32'h77, 0,32'h0, 1,32'h1234_5678, 1};
    vecs[18] = '{0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 32'h0,
                 0,0,32'h30,32'h77, 0,32'h0, 0,32'h1234_5678, 0};

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      m0_req   = vecs[i].m0_req;   m0_wr    = vecs[i].m0_wr;
      m0_addr  = vecs[i].m0_addr;  m0_wdata = vecs[i].m0_wdata;
      m1_req   = vecs[i].m1_req;   m1_wr    = vecs[i].m1_wr;
      m1_addr  = vecs[i].m1_addr;  m1_wdata = vecs[i].m1_wdata;
      bus_din  = vecs[i].bus_din;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rd_en", i),   32'(rd_en),   32'(vecs[i].e_rd));
      chk($sformatf("v%0d wr_en", i),   32'(wr_en),   32'(vecs[i].e_wr));
      chk($sformatf("v%0d addr", i),    bus_addr,     vecs[i].e_addr);
      chk($sformatf("v%0d bus_dout", i), bus_dout,    vecs[i].e_dout);
      chk($sformatf("v%0d m0_ack", i),  32'(m0_ack),  32'(vecs[i].e_m0_ack));
      chk($sformatf("v%0d m0_data", i), m0_dout,      vecs[i].e_m0_d);
      chk($sformatf("v%0d m1_ack", i),  32'(m1_ack),  32'(vecs[i].e_m1_ack));
      chk($sformatf("v%0d m1_data", i), m1_dout,      vecs[i].e_m1_d);
      chk($sformatf("v%0d busy", i),    32'(busy),    32'(vecs[i].e_busy));
    end

    // Both masters request continuously; m1 won last, so m0 goes first.
    n    = 0;
    dual = 0;
    @(negedge clk);
    m0_req = 1; m0_wr = 0; m0_addr = 32'h40;
    m1_req = 1; m1_wr = 0; m1_addr = 32'h44;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge clk);
      #1;
      if (m0_ack && m1_ack) dual++;
      if ((m0_ack || m1_ack) && n < 8) begin
        seq[n] = m1_ack ? 1 : 0;
        at[n]  = cyc;
        n++;
      end
    end
    chk("contend ack_count", 32'(n), 32'd4);
    chk("contend dual_ack", 32'(dual), 32'd0);
    for (int k = 0; k < 4 && k < n; k++) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
      chk($sformatf("contend grant%0d", k), 32'(seq[k]), 32'd0);
`else
      chk($sformatf("contend grant%0d", k), 32'(seq[k]), 32'(k % 2));
`endif
      chk($sformatf("contend ack_cycle%0d", k), 32'(at[k]), 32'(3 + 4 * k));
    end
    @(negedge clk);
    m0_req = 0; m1_req = 0;
    @(posedge clk);
    #1;
    chk("contend idle_busy", 32'(busy), 32'd0);

    // LATENCY=3 read: data must be the value present three cycles after ACCESS.
    ack_cnt2 = 0;
    ack_cyc2 = 0;
    ack_dat2 = 32'h0;
    acked    = 1'b0;
    @(negedge clk);
    req2 = 1;
    din2 = 32'h100;
    @(posedge clk);
    #1;
    chk("lat3 rd_en", 32'(rd_en2), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      din2 = 32'h100 + 32'(k);
      if (acked) req2 = 0;
      @(posedge clk);
      #1;
      if (m0_ack2) begin
        ack_cnt2++;
        ack_cyc2 = k + 1;
        ack_dat2 = m0_dout2;
        acked    = 1'b1;
      end
    end
    chk("lat3 ack_count", 32'(ack_cnt2), 32'd1);
    chk("lat3 ack_cycle", 32'(ack_cyc2), 32'd5);
    chk("lat3 data", ack_dat2, 32'h104);
    chk("lat3 data_hold", m0_dout2, 32'h104);
    chk("lat3 busy", 32'(busy2), 32'd0);
    chk("lat3 m1_ack", 32'(m1_ack2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
